alu_exu_pipe: RTL and testbench

// - Parametrised integer ALU execution unit between the ALU reservation station and the CDB arbiter.
// - Accepts one op per cycle. The op passes through LAT pipeline stages into a DEPTH-entry result FIFO.
// - The FIFO drains to the CDB under a req/rdy handshake.
// - Adds configurable latency, credit-based backpressure and synchronous flush (mispredict recovery).

---
 rtl/alu_exu_pipe.sv | 196 +++++++++++++++++++
 tb/tb_alu_exu_pipe.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exu_pipe.sv
// Integer ALU execution unit: LAT-stage pipe into a DEPTH-entry result FIFO
// drained to the CDB under req/rdy, with credit backpressure and flush.
// Optional ALU_MINMAX_EN adds min/max/minu/maxu at opcodes 4'hC..4'hF.
module alu_exu_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4,
  parameter int unsigned OPC_W = 4,
  parameter int unsigned LAT   = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rvs_req,
  output logic             rvs_rdy,
  input  logic [OPC_W-1:0] rvs_opc,
  input  logic [XLEN-1:0]  rvs_src1,
  input  logic [XLEN-1:0]  rvs_src2,
  input  logic [TAG_W-1:0] rvs_tag,
  input  logic             flush,
  output logic             cdb_req,
  input  logic             cdb_rdy,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [XLEN-1:0]  cdb_wdata
);

  localparam int unsigned SH_W  = $clog2(XLEN);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + LAT) + 1;

  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_SLL  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_SLT  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_SLTU = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_XOR  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SRL  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_SRA  = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(9);
`ifdef ALU_MINMAX_EN
  localparam logic [OPC_W-1:0] OP_MIN  = OPC_W'(12);
  localparam logic [OPC_W-1:0] OP_MAX  = OPC_W'(13);
  localparam logic [OPC_W-1:0] OP_MINU = OPC_W'(14);
  localparam logic [OPC_W-1:0] OP_MAXU = OPC_W'(15);
`endif

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
  } res_t;

  logic             issue;
  logic             pop;
  logic [SH_W-1:0]  shamt;
  logic [XLEN-1:0]  alu_res_c;
  res_t             s0;
  logic             wr_en;
  res_t             wr_ent;
  logic [CNT_W-1:0] inflight_c;
  logic [CNT_W-1:0] occ_c;

  res_t             mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_n, wr_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  res_t             head_q, head_n;
  res_t             last_q, last_n;
  logic             req_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign shamt = rvs_src2[SH_W-1:0];

  // Stage 0: combinational ALU; unknown opcodes yield zero
  always_comb begin
    alu_res_c = '0;
    case (rvs_opc)
      OP_ADD:  alu_res_c = rvs_src1 + rvs_src2;
      OP_SUB:  alu_res_c = rvs_src1 - rvs_src2;
      OP_SLL:  alu_res_c = rvs_src1 << shamt;
      OP_SLT:  alu_res_c = XLEN'($signed(rvs_src1) < $signed(rvs_src2));
      OP_SLTU: alu_res_c = XLEN'(rvs_src1 < rvs_src2);
      OP_XOR:  alu_res_c = rvs_src1 ^ rvs_src2;
      OP_SRL:  alu_res_c = rvs_src1 >> shamt;
      OP_SRA:  alu_res_c = $unsigned($signed(rvs_src1) >>> shamt);
      OP_OR:   alu_res_c = rvs_src1 | rvs_src2;
      OP_AND:  alu_res_c = rvs_src1 & rvs_src2;
`ifdef ALU_MINMAX_EN
      OP_MIN:  alu_res_c = ($signed(rvs_src1) < $signed(rvs_src2)) ? rvs_src1 : rvs_src2;
      OP_MAX:  alu_res_c = ($signed(rvs_src1) < $signed(rvs_src2)) ? rvs_src2 : rvs_src1;
      OP_MINU: alu_res_c = (rvs_src1 < rvs_src2) ? rvs_src1 : rvs_src2;
      OP_MAXU: alu_res_c = (rvs_src1 < rvs_src2) ? rvs_src2 : rvs_src1;
`endif
      default: alu_res_c = '0;
    endcase
  end

  assign s0 = '{tag: rvs_tag, data: alu_res_c};

  generate
    if (LAT == 1) begin : g_nopipe
      assign wr_en      = issue;
      assign wr_ent     = s0;
      assign inflight_c = '0;
    end else begin : g_pipe
      logic [LAT-2:0] stg_v;
      res_t           stg_d [LAT-1];

      // Delay stages; flush kills every valid bit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          stg_v <= '0;
          for (int i = 0; i < int'(LAT) - 1; i++) stg_d[i] <= '0;
        end else begin
          stg_v[0] <= issue;
          stg_d[0] <= s0;
          for (int i = 1; i < int'(LAT) - 1; i++) begin
            stg_v[i] <= stg_v[i-1] && !flush;
            stg_d[i] <= stg_d[i-1];
          end
        end
      end

      always_comb begin
        inflight_c = '0;
        for (int i = 0; i < int'(LAT) - 1; i++) inflight_c = inflight_c + CNT_W'(stg_v[i]);
      end

      assign wr_en  = stg_v[LAT-2];
      assign wr_ent = stg_d[LAT-2];
    end
  endgenerate

  // Credit: every op in flight already owns a FIFO slot
  assign pop     = req_q && cdb_rdy;
  assign occ_c   = cnt + inflight_c;
  assign rvs_rdy = !flush && ((occ_c - CNT_W'(pop)) < CNT_W'(DEPTH));
  assign issue   = rvs_req && rvs_rdy;

  // FIFO next state; the output register tracks the head, or the last popped entry when empty
  always_comb begin
    cnt_n  = cnt;
    rd_n   = rd_ptr;
    wr_n   = wr_ptr;
    head_n = head_q;
    last_n = last_q;
    if (pop) begin
      last_n = head_q;
      rd_n   = ptr_inc(rd_ptr);
    end
    if (flush) begin
      cnt_n = '0;
      rd_n  = '0;
      wr_n  = '0;
    end else begin
      if (wr_en) wr_n = ptr_inc(wr_ptr);
      cnt_n = cnt + CNT_W'(wr_en) - CNT_W'(pop);
    end
    if (cnt_n == '0) head_n = pop ? head_q : last_q;
    else if (pop)    head_n = (cnt == CNT_W'(1)) ? wr_ent : mem[ptr_inc(rd_ptr)];
    else if (cnt == '0) head_n = wr_ent;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      head_q <= '0;
      last_q <= '0;
      req_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      rd_ptr <= rd_n;
      wr_ptr <= wr_n;
      cnt    <= cnt_n;
      head_q <= head_n;
      last_q <= last_n;
      req_q  <= (cnt_n != '0);
      if (wr_en && !flush) mem[wr_ptr] <= wr_ent;
    end
  end

  assign cdb_req   = req_q;
  assign cdb_tag   = head_q.tag;
  assign cdb_wdata = head_q.data;

`ifndef SYNTHESIS
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n) pop |-> (cnt != '0));
  a_no_wr_full:   assert property (@(posedge clk) disable iff (!rst_n)
                    (wr_en && !flush) |-> ((cnt != CNT_W'(DEPTH)) || pop));
  a_occ_bound:    assert property (@(posedge clk) disable iff (!rst_n) occ_c <= CNT_W'(DEPTH));
`endif

endmodule

// File: tb/tb_alu_exu_pipe.sv
// Self-checking bench for alu_exu_pipe: queue-based reference model with a per-cycle
// compare process, directed literal checks and randomized traffic.
module tb_alu_exu_pipe;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned OPC_W = 4;
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic             rvs_req;
  logic             rvs_rdy;
  logic [OPC_W-1:0] rvs_opc;
  logic [XLEN-1:0]  rvs_src1;
  logic [XLEN-1:0]  rvs_src2;
  logic [TAG_W-1:0] rvs_tag;
  logic             flush;
  logic             cdb_req;
  logic             cdb_rdy;
  logic [TAG_W-1:0] cdb_tag;
  logic [XLEN-1:0]  cdb_wdata;

  alu_exu_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .OPC_W(OPC_W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rvs_req(rvs_req), .rvs_rdy(rvs_rdy), .rvs_opc(rvs_opc),
    .rvs_src1(rvs_src1), .rvs_src2(rvs_src2), .rvs_tag(rvs_tag), .flush(flush),
    .cdb_req(cdb_req), .cdb_rdy(cdb_rdy), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference ALU straight from the opcode table
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    logic [31:0] r;
    sh = int'(b[4:0]);
    r  = 32'h0;
    case (op)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a << sh;
      4'h3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h4: r = (a < b) ? 32'd1 : 32'd0;
      4'h5: r = a ^ b;
      4'h6: r = a >> sh;
      4'h7: r = $unsigned($signed(a) >>> sh);
      4'h8: r = a | b;
      4'h9: r = a & b;
`ifdef ALU_MINMAX_EN
      4'hC: r = ($signed(a) <= $signed(b)) ? a : b;
      4'hD: r = ($signed(a) >= $signed(b)) ? a : b;
      4'hE: r = (a <= b) ? a : b;
      4'hF: r = (a >= b) ? a : b;
`endif
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Model: every accepted op is an entry visible to the CDB from cycle issue+LAT on
  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
    int          due;
  } ent_t;

  ent_t        mq[$];
  int          cyc;
  logic [3:0]  lp_tag;
  logic [31:0] lp_data;

  function automatic bit m_req();
    return (mq.size() > 0) && (mq[0].due <= cyc);
  endfunction

  function automatic bit m_rdy();
    int p;
    p = (m_req() && cdb_rdy) ? 1 : 0;
    return !flush && ((mq.size() - p) < int'(DEPTH));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      cyc     = 0;
      lp_tag  = '0;
      lp_data = '0;
    end else begin
      bit   p_m;
      bit   i_m;
      ent_t e;
      p_m = m_req() && cdb_rdy;
      i_m = rvs_req && m_rdy();
      if (p_m) begin
        lp_tag  = mq[0].tag;
        lp_data = mq[0].data;
        void'(mq.pop_front());
      end
      if (flush) mq.delete();
      else if (i_m) begin
        e.tag  = rvs_tag;
        e.data = ref_alu(rvs_opc, rvs_src1, rvs_src2);
        e.due  = cyc + int'(LAT);
        mq.push_back(e);
      end
      cyc++;
    end
  end

  // Compare process, away from the active edge
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_cdb_req", 32'(cdb_req), 32'd0);
      chk("rst_cdb_tag", 32'(cdb_tag), 32'd0);
      chk("rst_cdb_wdata", cdb_wdata, 32'd0);
    end else begin
      chk("cdb_req", 32'(cdb_req), 32'(m_req()));
      chk("rvs_rdy", 32'(rvs_rdy), 32'(m_rdy()));
      if (m_req()) begin
        chk("cdb_tag", 32'(cdb_tag), 32'(mq[0].tag));
        chk("cdb_wdata", cdb_wdata, mq[0].data);
      end else begin
        chk("hold_tag", 32'(cdb_tag), 32'(lp_tag));
        chk("hold_wdata", cdb_wdata, lp_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op_check(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] tag, input logic [31:0] exp);
    int w;
    step();
    rvs_req = 1'b1; rvs_opc = op; rvs_src1 = a; rvs_src2 = b; rvs_tag = tag; cdb_rdy = 1'b1;
    step();
    rvs_req = 1'b0;
    w = 1;
    @(negedge clk);
    while (!cdb_req && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("op_latency", 32'(w), 32'(LAT));
    chk("op_tag", 32'(cdb_tag), 32'(tag));
    chk("op_data", cdb_wdata, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected end before %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int acc, iss, pops, seen, del;
    logic [3:0]  t;
    logic [31:0] exp_min, exp_minu;
    logic [31:0] specials [4];
    specials[0] = 32'h0; specials[1] = 32'hFFFF_FFFF;
    specials[2] = 32'h8000_0000; specials[3] = 32'h7FFF_FFFF;

    rst_n = 1'b0; rvs_req = 1'b0; rvs_opc = '0; rvs_src1 = '0; rvs_src2 = '0;
    rvs_tag = '0; flush = 1'b0; cdb_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed ops with hand-computed results
    op_check(4'h0, 32'd7, 32'd5, 4'd1, 32'd12);
    op_check(4'h1, 32'd3, 32'd5, 4'd2, 32'hFFFF_FFFE);
    op_check(4'h7, 32'h8000_0000, 32'd4, 4'd3, 32'hF800_0000);
    op_check(4'h3, 32'hFFFF_FFFF, 32'd1, 4'd4, 32'd1);
    op_check(4'h4, 32'hFFFF_FFFF, 32'd1, 4'd5, 32'd0);
    op_check(4'h2, 32'h0000_0003, 32'd36, 4'd6, 32'h0000_0030);
    op_check(4'h6, 32'h8000_0000, 32'd31, 4'd7, 32'h0000_0001);
    op_check(4'h5, 32'hF0F0_0000, 32'h0FF0_0000, 4'd8, 32'hFF00_0000);
    op_check(4'hA, 32'h1234_5678, 32'h1, 4'd9, 32'h0);
`ifdef ALU_MINMAX_EN
    exp_min = 32'hFFFF_FFFD; exp_minu = 32'd2;
`else
    exp_min = 32'h0; exp_minu = 32'h0;
`endif
    op_check(4'hC, 32'hFFFF_FFFD, 32'd2, 4'd10, exp_min);
    op_check(4'hE, 32'hFFFF_FFFD, 32'd2, 4'd11, exp_minu);

    // Backpressure: CDB stalled, issue every cycle
    step();
    cdb_rdy = 1'b0; rvs_req = 1'b1; rvs_opc = 4'h0; t = 4'd0; acc = 0;
    for (int i = 0; i < 8; i++) begin
      rvs_tag = t; rvs_src1 = $urandom; rvs_src2 = $urandom;
      @(negedge clk);
      if (rvs_rdy) begin acc++; t = t + 4'd1; end
      step();
    end
    chk("bp_accepted", 32'(acc), 32'(DEPTH));

    // Full FIFO with both sides active: one issue and one pop per cycle
    cdb_rdy = 1'b1; iss = 0; pops = 0;
    for (int i = 0; i < 16; i++) begin
      rvs_tag = t; rvs_opc = 4'($urandom_range(0, 15));
      rvs_src1 = $urandom; rvs_src2 = $urandom;
      @(negedge clk);
      if (rvs_rdy) begin iss++; t = t + 4'd1; end
      if (cdb_req) pops++;
      step();
    end
    chk("b2b_issues", 32'(iss), 32'd16);
    chk("b2b_pops", 32'(pops), 32'd16);
    rvs_req = 1'b0;
    repeat (8) step();

    // Flush with two buffered and one in flight
    cdb_rdy = 1'b0; rvs_req = 1'b1; rvs_opc = 4'h8;
    for (int i = 0; i < 3; i++) begin
      rvs_tag = 4'(13 + i); rvs_src1 = 32'h1111_0000; rvs_src2 = 32'(i + 1);
      step();
    end
    flush = 1'b1; rvs_tag = 4'd12;
    @(negedge clk);
    chk("flush_rdy", 32'(rvs_rdy), 32'd0);
    step();
    flush = 1'b0; rvs_req = 1'b0; cdb_rdy = 1'b1;
    @(negedge clk);
    chk("flush_req", 32'(cdb_req), 32'd0);
    step();
    rvs_req = 1'b1; rvs_tag = 4'd6; rvs_opc = 4'h0; rvs_src1 = 32'd40; rvs_src2 = 32'd2;
    step();
    rvs_req = 1'b0;
    seen = 0; del = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cdb_req && cdb_tag >= 4'd12) seen++;
      if (cdb_req && cdb_tag == 4'd6) begin
        del++;
        chk("flush_new_data", cdb_wdata, 32'd42);
      end
      step();
    end
    chk("flush_killed_seen", 32'(seen), 32'd0);
    chk("flush_new_delivered", 32'(del), 32'd1);

    // Reset mid-stream with two results buffered
    cdb_rdy = 1'b0; rvs_req = 1'b1; rvs_opc = 4'h8; rvs_src1 = 32'hABCD_0000; rvs_src2 = 32'h1;
    rvs_tag = 4'd7; step();
    rvs_tag = 4'd8; step();
    rvs_req = 1'b0;
    repeat (3) step();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_now_req", 32'(cdb_req), 32'd0);
    chk("rst_now_tag", 32'(cdb_tag), 32'd0);
    chk("rst_now_wdata", cdb_wdata, 32'd0);
    repeat (2) step();
    rst_n = 1'b1; cdb_rdy = 1'b1;
    @(negedge clk);
    chk("rst_rel_rdy", 32'(rvs_rdy), 32'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cdb_req) seen++;
    end
    chk("rst_no_result", 32'(seen), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step();
      rvs_req  = ($urandom_range(0, 3) != 0);
      cdb_rdy  = (i % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 39) == 0);
      rvs_opc  = 4'($urandom_range(0, 15));
      rvs_tag  = 4'($urandom_range(0, 15));
      rvs_src1 = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      rvs_src2 = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
    end
    step();
    rvs_req = 1'b0; flush = 1'b0; cdb_rdy = 1'b1;
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
